axis_frame_gen: RTL and testbench

- AXI4-Stream frame transmitter that drives the input side of the stream FIFOs in the passthrough demo.
- Generates a programmed number of frames, each of a programmed byte length, with a deterministic byte pattern.
- Places TKEEP, TLAST, TID, TDEST and TUSER exactly as the FIFO expects, including the bad-frame marker.
- Serves as the stimulus source for FIFO, frame-drop and back-pressure testing in hardware and simulation.

---
 rtl/axis_demo_pkg.sv | 21 ++
 rtl/axis_frame_gen_if.sv | 27 ++
 rtl/axis_frame_gen.sv | 178 +++++++++++++++++
 tb/tb_axis_frame_gen.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_demo_pkg.sv
// Shared definitions for the AXI4-Stream passthrough demo: generator FSM states,
// last-beat byte-enable rule and the deterministic byte pattern.
package axis_demo_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap,
        StDone
    } gen_state_e;

    // Last-beat TKEEP bit for one lane; a zero remainder means the beat is full.
    function automatic logic keep_mask(input int unsigned rem, input int unsigned lane);
        return (rem == 0) || (lane < rem);
    endfunction

    function automatic logic [7:0] pattern_byte(input logic [7:0] frame, input logic [7:0] idx);
        return frame + idx;
    endfunction

endpackage

// File: rtl/axis_frame_gen_if.sv
// AXI4-Stream bundle between the frame generator and the downstream stream FIFO.
interface axis_frame_gen_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] TDATA;
    logic [KEEP_WIDTH-1:0] TKEEP;
    logic                  TVALID;
    logic                  TREADY;
    logic                  TLAST;
    logic [ID_WIDTH-1:0]   TID;
    logic [DEST_WIDTH-1:0] TDEST;
    logic [USER_WIDTH-1:0] TUSER;

    modport master (
        output TDATA, TKEEP, TVALID, TLAST, TID, TDEST, TUSER,
        input  TREADY
    );

    modport slave (
        input  TDATA, TKEEP, TVALID, TLAST, TID, TDEST, TUSER,
        output TREADY
    );
endinterface

// File: rtl/axis_frame_gen.sv
// Programmable AXI4-Stream frame source: sends cfg_frames frames of cfg_len_bytes bytes
// with a (frame + byte) mod 256 pattern and optional idle gaps between frames.
module axis_frame_gen
    import axis_demo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  cfg_start,
    input  logic [LEN_WIDTH-1:0]  cfg_len_bytes,
    input  logic [CNT_WIDTH-1:0]  cfg_frames,
    input  logic [7:0]            cfg_gap,
    input  logic [ID_WIDTH-1:0]   cfg_id,
    input  logic [DEST_WIDTH-1:0] cfg_dest,
    input  logic [USER_WIDTH-1:0] cfg_user_last,
    axis_frame_gen_if.master      output_r,
    output logic                  status_busy,
    output logic                  status_done,
    output logic [CNT_WIDTH-1:0]  status_frames_sent
);

    gen_state_e            state_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  frames_q;
    logic [7:0]            gap_q;
    logic [USER_WIDTH-1:0] user_q;
    logic [7:0]            frame_idx_q;
    logic [LEN_WIDTH-1:0]  byte_off_q;
    logic [7:0]            gap_cnt_q;
    logic [CNT_WIDTH-1:0]  sent_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  tvalid_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic [KEEP_WIDTH-1:0] tkeep_q;
    logic                  tlast_q;
    logic [ID_WIDTH-1:0]   tid_q;
    logic [DEST_WIDTH-1:0] tdest_q;
    logic [USER_WIDTH-1:0] tuser_q;

    // Next beat to present: frame_idx_q / byte_off_q always point at it.
    logic [DATA_WIDTH-1:0] beat_data;
    logic [KEEP_WIDTH-1:0] beat_keep;
    logic                  beat_last;
    logic [LEN_WIDTH:0]    beat_end;
    int unsigned           last_rem;

    assign beat_end  = {1'b0, byte_off_q} + (LEN_WIDTH+1)'(KEEP_WIDTH);
    assign beat_last = beat_end >= {1'b0, len_q};
    assign last_rem  = 32'(len_q % LEN_WIDTH'(KEEP_WIDTH));

    for (genvar j = 0; j < KEEP_WIDTH; j++) begin : g_lane
        logic [7:0] lane_off;
        assign lane_off             = byte_off_q[7:0] + 8'(j);
        assign beat_keep[j]         = beat_last ? keep_mask(last_rem, j) : 1'b1;
        assign beat_data[8*j +: 8]  = beat_keep[j] ? pattern_byte(frame_idx_q, lane_off) : 8'h00;
    end

    logic frame_end;
    logic last_frame;
    logic load_beat;

    always_comb begin
        frame_end  = (state_q == StSend) && tvalid_q && output_r.TREADY && tlast_q;
        last_frame = (sent_q + CNT_WIDTH'(1)) == frames_q;
        load_beat  = 1'b0;
        case (state_q)
            // Back-to-back frames reload straight after the last beat when no gap is set.
            StSend:  load_beat = !tvalid_q ||
                                 (output_r.TREADY && (!tlast_q || (!last_frame && gap_q == 8'd0)));
            StGap:   load_beat = (gap_cnt_q == 8'd1);
            default: load_beat = 1'b0;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            frames_q    <= '0;
            gap_q       <= '0;
            user_q      <= '0;
            frame_idx_q <= '0;
            byte_off_q  <= '0;
            gap_cnt_q   <= '0;
            sent_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tid_q       <= '0;
            tdest_q     <= '0;
            tuser_q     <= '0;
        end else begin
            done_q <= 1'b0;

            if (load_beat) begin
                tvalid_q <= 1'b1;
                tdata_q  <= beat_data;
                tkeep_q  <= beat_keep;
                tlast_q  <= beat_last;
                tuser_q  <= beat_last ? user_q : '0;
                if (beat_last) begin
                    byte_off_q  <= '0;
                    frame_idx_q <= frame_idx_q + 8'd1;
                end else begin
                    byte_off_q <= byte_off_q + LEN_WIDTH'(KEEP_WIDTH);
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (cfg_start) begin
                        len_q       <= cfg_len_bytes;
                        frames_q    <= cfg_frames;
                        gap_q       <= cfg_gap;
                        user_q      <= cfg_user_last;
                        tid_q       <= cfg_id;
                        tdest_q     <= cfg_dest;
                        frame_idx_q <= '0;
                        byte_off_q  <= '0;
                        sent_q      <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= (cfg_frames == '0 || cfg_len_bytes == '0) ? StDone : StSend;
                    end
                end
                StSend: begin
                    if (frame_end) begin
                        sent_q <= sent_q + CNT_WIDTH'(1);
                        if (last_frame) begin
                            tvalid_q <= 1'b0;
                            state_q  <= StDone;
                        end else if (gap_q != 8'd0) begin
                            tvalid_q  <= 1'b0;
                            gap_cnt_q <= gap_q;
                            state_q   <= StGap;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == 8'd1) begin
                        state_q <= StSend;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign output_r.TVALID = tvalid_q;
    assign output_r.TDATA  = tdata_q;
    assign output_r.TKEEP  = tkeep_q;
    assign output_r.TLAST  = tlast_q;
    assign output_r.TID    = tid_q;
    assign output_r.TDEST  = tdest_q;
    assign output_r.TUSER  = tuser_q;

    assign status_busy        = busy_q;
    assign status_done        = done_q;
    assign status_frames_sent = sent_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Randomised bench for axis_frame_gen against a byte-level frame model.
module tb_axis_frame_gen;

    localparam int KW = 4;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
        logic [7:0]  id;
        logic [7:0]  dest;
    } beat_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_len_bytes = '0;
    logic [15:0] cfg_frames = '0;
    logic [7:0]  cfg_gap = '0;
    logic [7:0]  cfg_id = '0;
    logic [7:0]  cfg_dest = '0;
    logic [0:0]  cfg_user_last = '0;
    logic        status_busy;
    logic        status_done;
    logic [15:0] status_frames_sent;

    axis_frame_gen_if #(
        .DATA_WIDTH(32),
        .KEEP_WIDTH(4),
        .ID_WIDTH  (8),
        .DEST_WIDTH(8),
        .USER_WIDTH(1)
    ) axis ();

    axis_frame_gen dut (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .cfg_start         (cfg_start),
        .cfg_len_bytes     (cfg_len_bytes),
        .cfg_frames        (cfg_frames),
        .cfg_gap           (cfg_gap),
        .cfg_id            (cfg_id),
        .cfg_dest          (cfg_dest),
        .cfg_user_last     (cfg_user_last),
        .output_r          (axis),
        .status_busy       (status_busy),
        .status_done       (status_done),
        .status_frames_sent(status_frames_sent)
    );

    always #5 ap_clk = ~ap_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ready_pct = 100;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int idle_cnt = 0;
    int frames_seen = 0;
    bit mon_en = 0;
    bit in_frame = 0;
    bit prev_v = 0;
    bit prev_r = 0;
    logic [63:0] prev_pay = '0;
    beat_t exp_q[$];
    beat_t got_q[$];
    int gaps_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] payload();
        return {10'd0, axis.TDATA, axis.TKEEP, axis.TLAST, axis.TUSER, axis.TID, axis.TDEST};
    endfunction

    // Byte stream model: byte k of frame f is (f + k) mod 256, little-endian lanes.
    task automatic build_expected(input int len, input int frames, input int user,
                                  input int id, input int dest);
        int nb;
        exp_q.delete();
        nb = (len + KW - 1) / KW;
        for (int f = 0; f < frames; f++) begin
            for (int b = 0; b < nb; b++) begin
                beat_t e;
                e.data = '0;
                e.keep = '0;
                for (int j = 0; j < KW; j++) begin
                    int k;
                    k = b * KW + j;
                    if (k < len) begin
                        e.data[8*j +: 8] = 8'((f + k) % 256);
                        e.keep[j]        = 1'b1;
                    end
                end
                e.last = (b == nb - 1);
                e.user = e.last ? 1'(user) : 1'b0;
                e.id   = 8'(id);
                e.dest = 8'(dest);
                exp_q.push_back(e);
            end
        end
    endtask

    // Cycle counter and randomised TREADY.
    initial forever begin
        @(posedge ap_clk);
        cyc++;
        #1;
        axis.TREADY = ($urandom_range(0, 99) < ready_pct);
    end

    // Monitor: collect accepted beats, inter-frame idle cycles, and stall stability.
    initial forever begin
        @(negedge ap_clk);
        if (status_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mon_en) begin
            if (prev_v && !prev_r) begin
                check("hold_valid", 64'(axis.TVALID), 64'd1);
                check("hold_payload", payload(), prev_pay);
            end
            if (axis.TVALID && !in_frame) begin
                if (frames_seen > 0) gaps_q.push_back(idle_cnt);
                in_frame = 1;
            end else if (!axis.TVALID && !in_frame) begin
                idle_cnt++;
            end
            if (axis.TVALID && axis.TREADY) begin
                got_q.push_back('{axis.TDATA, axis.TKEEP, axis.TLAST, axis.TUSER[0],
                                  axis.TID, axis.TDEST});
                if (axis.TLAST) begin
                    in_frame = 0;
                    idle_cnt = 0;
                    frames_seen++;
                end
            end
            prev_v   = axis.TVALID;
            prev_r   = axis.TREADY;
            prev_pay = payload();
        end
    end

    task automatic monitor_clear();
        got_q.delete();
        gaps_q.delete();
        done_cnt    = 0;
        idle_cnt    = 0;
        frames_seen = 0;
        in_frame    = 0;
        prev_v      = 0;
        prev_r      = 0;
    endtask

    task automatic run(input int len, input int frames, input int gap, input int id,
                       input int dest, input int user, input int rpct, input int poke);
        int n;
        int budget;
        int nb;
        int latency;
        int exp_sent;
        build_expected(len, frames, user, id, dest);
        monitor_clear();
        ready_pct = rpct;
        mon_en    = 1;
        @(posedge ap_clk); #1;
        cfg_len_bytes = 16'(len);
        cfg_frames    = 16'(frames);
        cfg_gap       = 8'(gap);
        cfg_id        = 8'(id);
        cfg_dest      = 8'(dest);
        cfg_user_last = 1'(user);
        cfg_start     = 1'b1;
        start_cyc     = cyc;
        @(posedge ap_clk); #1;
        cfg_start = 1'b0;
        check("busy_after_start", 64'(status_busy), 64'd1);
        check("sent_cleared", 64'(status_frames_sent), 64'd0);
        if (poke != 0) begin
            cfg_len_bytes = 16'd3;
            cfg_frames    = 16'd9;
            cfg_gap       = 8'd0;
            cfg_id        = 8'hEE;
            cfg_dest      = 8'hDD;
            cfg_user_last = 1'b0;
        end
        nb     = (len + KW - 1) / KW;
        budget = 12 * (frames + 1) * (nb + gap + 2) + 20;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge ap_clk); #1;
            n++;
            cfg_start = (poke != 0 && n == 3);
        end
        cfg_start = 1'b0;
        check("run_done_in_budget", 64'(done_cnt != 0), 64'd1);
        latency = done_cyc - start_cyc;
        repeat (3) @(posedge ap_clk);
        #1;
        mon_en = 0;
        exp_sent = (len == 0) ? 0 : frames;
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("busy_idle", 64'(status_busy), 64'd0);
        check("frames_sent", 64'(status_frames_sent), 64'(16'(exp_sent)));
        check("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check("tdata", 64'(got_q[i].data), 64'(exp_q[i].data));
            check("tkeep", 64'(got_q[i].keep), 64'(exp_q[i].keep));
            check("tlast", 64'(got_q[i].last), 64'(exp_q[i].last));
            check("tuser", 64'(got_q[i].user), 64'(exp_q[i].user));
            check("tid", 64'(got_q[i].id), 64'(exp_q[i].id));
            check("tdest", 64'(got_q[i].dest), 64'(exp_q[i].dest));
        end
        if (rpct == 100 && len > 0 && frames > 0) begin
            check("gap_count", 64'(gaps_q.size()), 64'(frames - 1));
            foreach (gaps_q[i]) check("gap_len", 64'(gaps_q[i]), 64'(gap));
        end
        if (frames == 0 || len == 0) check("empty_done_latency", 64'(latency), 64'd2);
    endtask

    initial begin
        int n;
        axis.TREADY = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_tvalid", 64'(axis.TVALID), 64'd0);
        check("rst_payload", payload(), 64'd0);
        check("rst_status", 64'({status_busy, status_done, status_frames_sent}), 64'd0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        check("idle_tvalid", 64'(axis.TVALID), 64'd0);

        run(10, 1, 0, 0, 0, 0, 100, 0);
        check("tp1_beat0", 64'(got_q[0].data), 64'h03020100);
        check("tp1_beat1", 64'(got_q[1].data), 64'h07060504);
        check("tp1_beat2", 64'(got_q[2].data), 64'h00000908);
        check("tp1_keep2", 64'(got_q[2].keep), 64'h3);

        run(8, 3, 2, 5, 10, 1, 100, 0);
        check("tp2_f2b0", 64'(got_q[4].data), 64'h05040302);

        run(16, 4, 0, 7, 3, 0, 30, 0);
        run(16, 4, 1, 1, 2, 1, 30, 0);
        run(0, 3, 1, 0, 0, 0, 100, 0);
        run(5, 0, 0, 0, 0, 0, 100, 0);
        run(12, 2, 1, 9, 8, 1, 100, 1);

        // Asynchronous reset while the second beat of a frame is on the bus.
        monitor_clear();
        ready_pct = 100;
        mon_en    = 1;
        @(posedge ap_clk); #1;
        cfg_len_bytes = 16'd20;
        cfg_frames    = 16'd1;
        cfg_gap       = 8'd0;
        cfg_start     = 1'b1;
        @(posedge ap_clk); #1;
        cfg_start = 1'b0;
        n = 0;
        while (got_q.size() < 1 && n < 20) begin
            @(posedge ap_clk); #1;
            n++;
        end
        check("rst_mid_valid", 64'(axis.TVALID), 64'd1);
        check("rst_mid_data", 64'(axis.TDATA), 64'h07060504);
        #2;
        mon_en   = 0;
        ap_rst_n = 1'b0;
        #1;
        check("rst_async_tvalid", 64'(axis.TVALID), 64'd0);
        check("rst_async_status", 64'({status_busy, status_frames_sent}), 64'd0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        run(6, 1, 0, 4, 4, 1, 100, 0);

        repeat (6) begin
            int pick;
            pick = $urandom_range(0, 2);
            run($urandom_range(1, 40), $urandom_range(1, 4), $urandom_range(0, 3),
                $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1),
                (pick == 0) ? 100 : ((pick == 1) ? 30 : 60), 0);
        end

        // Frame index wraps in the pattern after 256 frames.
        run(1, 260, 0, 0, 0, 1, 100, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
